ifu_fetch: RTL
==============

# ifu_fetch

Instruction-fetch controller for the Gemini dual-issue front end. It holds the architectural fetch PC, issues one SRAM-like instruction request per bundle and returns up to two instructions per response. It drives `inst_rdata_1_ok`/`inst_rdata_2_ok` and `pc` back to the next-PC logic, and loads that logic's `next_pc` result. It also owns request cancellation on decode-stage redirects and buffers a returned bundle while decode is stalled.

## Interface
- `RESET_PC`, 32'hBFC0_0000, PC value loaded on reset.
- `clk  in  1`  rising-edge clock.
- `resetn  in  1`  asynchronous, active-low reset.
- `next_pc  in  32`  next-PC result; loaded into `pc` on every update cycle.
- `redirect  in  1`  OR of decode-stage jump/branch/jr taken; `next_pc` carries the target.
- `id_stall  in  1`  decode cannot accept a bundle this cycle.
- `pc  out  32`  current fetch PC; the address of the bundle being fetched.
- `inst_req  out  1`, `inst_addr  out  32`  request to instruction memory.
- `inst_addr_ok  in  1`  request accepted.
- `inst_data_ok  in  1`, `inst_rdata_1  in  32`, `inst_rdata_2  in  32`  response for words at `inst_addr` and `inst_addr+4`.
- `inst_rdata_1_ok  out  1`, `inst_rdata_2_ok  out  1`  slot 1 / slot 2 instruction delivered to decode this cycle.
- `if_inst_1  out  32`, `if_inst_2  out  32`, `if_pc  out  32`  delivered bundle and the PC of slot 1.

## Operation
- FSM states: IDLE, REQ, WAIT, CANCEL, HOLD. Reset enters IDLE with `pc`=`RESET_PC` and all outputs 0. `if_*` outputs are 0 on reset.
- IDLE: goes to REQ after one cycle.
- REQ: `inst_req`=1, `inst_addr`=`pc`. On `inst_addr_ok`, go to WAIT.
- WAIT: on `inst_data_ok` with no `redirect`:
  - Without `id_stall`: deliver the bundle and go to REQ.
  - With `id_stall`: capture both words into the hold buffer and go to HOLD.
- HOLD: present the buffer. Deliver when `id_stall` drops, then go to REQ.
- Delivery: `inst_rdata_1_ok`=1. `inst_rdata_2_ok`=1 only when `pc[2]`=0, i.e. the bundle is 8-byte aligned; otherwise slot 2 is suppressed. `if_pc`=`pc`.
- `pc` update: `pc <= next_pc` in each delivery cycle and each `redirect` cycle; otherwise `pc` holds. The next-PC logic returns `pc+4` or `pc+8` from the ok flags.
- Redirect has priority over delivery. No ok flag is asserted that cycle, and `pc` loads the target.
  - In REQ without `inst_addr_ok`: stay in REQ; `inst_addr` follows the new `pc`.
  - In REQ with `inst_addr_ok`, or in WAIT without `inst_data_ok`: go to CANCEL.
  - In WAIT with `inst_data_ok`, or in HOLD: drop the data and go to REQ.
- CANCEL: `inst_req`=0. Wait for `inst_data_ok`, discard the response, then go to REQ. A further `redirect` in CANCEL only reloads `pc`.
- At most one outstanding request at any time.

## Timing
- Minimum bundle period is 2 cycles: REQ with immediate `addr_ok`, then WAIT with `data_ok` next cycle.
- Ok flags are combinational from state, `inst_data_ok`, `id_stall` and `redirect`. No more than one bundle is delivered per cycle.
- `pc`, state and the hold buffer are registered. All are cleared asynchronously on `resetn` low, including mid-request. A response arriving after reset deasserts is ignored only if the memory side is also reset.
- The `pc`+8 sum wraps modulo 2^32; no overflow detection.

## Configuration
- `GEMINI_DUAL_FETCH_EN` defined: behaviour as above.
- Not defined: `inst_rdata_2_ok` is tied to 0 and `if_inst_2` to 0. The `inst_rdata_2` input is ignored and not stored in the hold buffer, and every bundle advances `pc` by 4.

## Structure
- A shared package `gemini_pkg` holds:
  - The FSM state enum.
  - `RESET_PC_DEFAULT`.
  - The fetch-bundle struct: two instructions plus PC.
- One sub-module, `ifu_hold_buf`: a single-entry bundle register with load/clear/valid. The FSM and the ok-flag logic stay in `ifu_fetch`.

## Test plan
- Reset release, memory answers `addr_ok` immediately and `data_ok` next cycle -> first request at 0xBFC00000. `inst_rdata_1_ok`=`inst_rdata_2_ok`=1, and `pc` becomes 0xBFC00008.
- `pc`=0xBFC00004 -> only `inst_rdata_1_ok`=1, and the next request is at 0xBFC00008.
- `id_stall`=1 for 3 cycles while data 0x24010001/0x24020002 returns -> no ok flags during the stall. Both words are delivered in the cycle `id_stall` falls, and `pc` advances by 8 that cycle.
- `redirect` with target 0xBFC00100 while in WAIT -> the next response is discarded with no ok flag, and the next request is at 0xBFC00100.
- `redirect` in the same cycle as `inst_data_ok` -> no ok flags, and `pc`=target the next cycle.
- `GEMINI_DUAL_FETCH_EN` undefined, aligned `pc` 0xBFC00000 -> `inst_rdata_2_ok`=0 and the next `pc` is 0xBFC00004.

Source files
------------

// File: rtl/gemini_pkg.sv
// Shared types for the Gemini front end: fetch FSM states, reset PC and the
// fetch-bundle record carried between the memory response and decode.
package gemini_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

  // Fetch controller states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_CANCEL = 3'd3,
    ST_HOLD   = 3'd4
  } fetch_state_e;

  // One fetched bundle: slot 1 word, slot 2 word and the PC of slot 1
  typedef struct packed {
    logic [31:0] inst_1;
    logic [31:0] inst_2;
    logic [31:0] pc;
  } fetch_bundle_t;

endpackage

// File: rtl/ifu_hold_buf.sv
// Single-entry bundle register. Keeps a returned bundle while decode is
// stalled. Load wins over clear when both are asserted.
module ifu_hold_buf
  import gemini_pkg::*;
(
  input  logic          clk,
  input  logic          resetn,
  input  logic          load,
  input  logic          clear,
  input  fetch_bundle_t din,
  output fetch_bundle_t dout,
  output logic          valid
);

  fetch_bundle_t bundle_q, bundle_d;
  logic          valid_q, valid_d;

  // Next-state of the entry: capture on load, empty on clear
  always_comb begin
    bundle_d = bundle_q;
    valid_d  = valid_q;
    if (load) begin
      bundle_d = din;
      valid_d  = 1'b1;
    end else if (clear) begin
      bundle_d = '0;
      valid_d  = 1'b0;
    end
  end

  // Entry registers, cleared asynchronously
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bundle_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      bundle_q <= bundle_d;
      valid_q  <= valid_d;
    end
  end

  assign dout  = bundle_q;
  assign valid = valid_q;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch controller: owns the fetch PC, issues one request per
// bundle, delivers up to two instructions to decode, cancels in-flight
// requests on redirect and parks a bundle while decode stalls.
// Build option: GEMINI_DUAL_FETCH_EN enables slot 2; without it every bundle
// carries a single instruction and the PC advances by 4.
//
// Handshake: a request is accepted in the cycle inst_req and inst_addr_ok are
// both high; the response is the single cycle inst_data_ok is high. Only one
// request is ever outstanding. A bundle reaches decode in the cycle
// inst_rdata_1_ok is high; decode signals it cannot take it with id_stall.
module ifu_fetch
  import gemini_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [31:0]  next_pc,
  input  logic         redirect,
  input  logic         id_stall,
  output logic [31:0]  pc,
  output logic         inst_req,
  output logic [31:0]  inst_addr,
  input  logic         inst_addr_ok,
  input  logic         inst_data_ok,
  input  logic [31:0]  inst_rdata_1,
  input  logic [31:0]  inst_rdata_2,
  output logic         inst_rdata_1_ok,
  output logic         inst_rdata_2_ok,
  output logic [31:0]  if_inst_1,
  output logic [31:0]  if_inst_2,
  output logic [31:0]  if_pc,
  output fetch_state_e dbg_state
);

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;

  logic          deliver_wait;
  logic          deliver_hold;
  logic          deliver;
  logic          hold_load;
  logic          hold_clear;
  logic          hold_valid;
  fetch_bundle_t hold_din;
  fetch_bundle_t hold_dout;
  logic [31:0]   word_2_in;

  // Second word is only carried when dual fetch is built in
`ifdef GEMINI_DUAL_FETCH_EN
  assign word_2_in = inst_rdata_2;
`else
  logic unused_word_2;
  assign word_2_in     = 32'h0;
  assign unused_word_2 = ^{inst_rdata_2, hold_dout.inst_2};
`endif

  // Delivery and hold-buffer control; redirect always suppresses delivery
  always_comb begin
    deliver_wait = (state_q == ST_WAIT) && inst_data_ok && !redirect && !id_stall;
    deliver_hold = (state_q == ST_HOLD) && hold_valid && !redirect && !id_stall;
    deliver      = deliver_wait || deliver_hold;
    hold_load    = (state_q == ST_WAIT) && inst_data_ok && !redirect && id_stall;
    hold_clear   = (state_q == ST_HOLD) && (redirect || !id_stall);
    hold_din.inst_1 = inst_rdata_1;
    hold_din.inst_2 = word_2_in;
    hold_din.pc     = pc_q;
  end

  ifu_hold_buf u_hold_buf (
    .clk    (clk),
    .resetn (resetn),
    .load   (hold_load),
    .clear  (hold_clear),
    .din    (hold_din),
    .dout   (hold_dout),
    .valid  (hold_valid)
  );

  // Fetch FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (inst_addr_ok) state_d = redirect ? ST_CANCEL : ST_WAIT;
      end
      ST_WAIT: begin
        if (redirect)          state_d = inst_data_ok ? ST_REQ : ST_CANCEL;
        else if (inst_data_ok) state_d = id_stall ? ST_HOLD : ST_REQ;
      end
      ST_CANCEL: begin
        if (inst_data_ok) state_d = ST_REQ;
      end
      ST_HOLD: begin
        if (redirect || !id_stall) state_d = ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // PC loads the next-PC result on every delivery and every redirect
  always_comb begin
    pc_d = pc_q;
    if (deliver || redirect) pc_d = next_pc;
  end

  // State and PC registers, cleared asynchronously
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Output drive: request port and the bundle presented to decode
  always_comb begin
    inst_req        = (state_q == ST_REQ);
    inst_addr       = inst_req ? pc_q : 32'h0;
    inst_rdata_1_ok = deliver;
`ifdef GEMINI_DUAL_FETCH_EN
    inst_rdata_2_ok = deliver && !pc_q[2];
`else
    inst_rdata_2_ok = 1'b0;
`endif
    if_inst_1 = 32'h0;
    if_inst_2 = 32'h0;
    if_pc     = 32'h0;
    if (deliver_wait) begin
      if_inst_1 = inst_rdata_1;
      if_inst_2 = word_2_in;
      if_pc     = pc_q;
    end else if (deliver_hold) begin
      if_inst_1 = hold_dout.inst_1;
      if_inst_2 = hold_dout.inst_2;
      if_pc     = hold_dout.pc;
    end
  end

  assign pc        = pc_q;
  assign dbg_state = state_q;

endmodule
